// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the scoreboard display path.
// Default 640x480@60 figures plus derived totals and sync windows.
package vga_timing_pkg;

    localparam int unsigned INDEX_W = 10;

    localparam int unsigned CLK_DIV_D  = 4;
    localparam int unsigned H_ACTIVE_D = 640;
    localparam int unsigned H_FP_D     = 16;
    localparam int unsigned H_SYNC_D   = 96;
    localparam int unsigned H_BP_D     = 48;
    localparam int unsigned V_ACTIVE_D = 480;
    localparam int unsigned V_FP_D     = 10;
    localparam int unsigned V_SYNC_D   = 2;
    localparam int unsigned V_BP_D     = 33;
    localparam int unsigned FPS_D      = 60;

    localparam int unsigned H_TOTAL = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int unsigned V_TOTAL = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
    localparam int unsigned HS_START = H_ACTIVE_D + H_FP_D;
    localparam int unsigned HS_END   = HS_START + H_SYNC_D;
    localparam int unsigned VS_START = V_ACTIVE_D + V_FP_D;
    localparam int unsigned VS_END   = VS_START + V_SYNC_D;

    typedef struct packed {
        logic [INDEX_W-1:0] h;
        logic [INDEX_W-1:0] v;
    } raster_t;

    // A modulus of 1 still needs a 1-bit register.
    function automatic int unsigned cnt_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_counter.sv
// Modulo-N counter used for every stage of the raster carry chain.
// Exposes the next-state value so callers can decode registered outputs.
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         clk_vga,
    input  logic         rst_vga,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         wrap
);

    assign wrap = (cnt == W'(N - 1));

    always_comb begin
        nxt = cnt;
        if (en) begin
            nxt = wrap ? '0 : cnt + W'(1);
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, syncs and ticks.
// Sync/video flags decode next-state counts so they align with the indices.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV        = CLK_DIV_D,
    parameter int unsigned H_ACTIVE       = H_ACTIVE_D,
    parameter int unsigned H_FP           = H_FP_D,
    parameter int unsigned H_SYNC         = H_SYNC_D,
    parameter int unsigned H_BP           = H_BP_D,
    parameter int unsigned V_ACTIVE       = V_ACTIVE_D,
    parameter int unsigned V_FP           = V_FP_D,
    parameter int unsigned V_SYNC         = V_SYNC_D,
    parameter int unsigned V_BP           = V_BP_D,
    parameter bit          HSYNC_POL      = 1'b0,
    parameter bit          VSYNC_POL      = 1'b0,
    parameter int unsigned FRAMES_PER_SEC = FPS_D
) (
    input  logic               clk_vga,
    input  logic               rst_vga,
    output logic [INDEX_W-1:0] h_index,
    output logic [INDEX_W-1:0] v_index,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               pix_tick,
    output logic               frame_tick,
    output logic               sec_tick
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_S  = H_ACTIVE + H_FP;
    localparam int unsigned HS_E  = HS_S + H_SYNC;
    localparam int unsigned VS_S  = V_ACTIVE + V_FP;
    localparam int unsigned VS_E  = VS_S + V_SYNC;
    localparam int unsigned DW    = cnt_w(CLK_DIV);
    localparam int unsigned FW    = cnt_w(FRAMES_PER_SEC);

    if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 1) begin : g_bad_cfg
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [DW-1:0] div, div_nxt;
    logic [FW-1:0] fc, fc_nxt;
    logic          div_wrap, h_wrap, v_wrap, fc_wrap;
    logic          h_en, v_en, fc_en;
    raster_t       nxt;
    int unsigned   h_n, v_n;
    logic          hs_act, vs_act, vis;
    logic          unused_bits;

    assign h_en = div_wrap;
    assign v_en = h_wrap & h_en;
    assign fc_en = v_wrap & v_en;

    mod_counter #(.N(CLK_DIV), .W(DW)) u_div (
        .clk_vga(clk_vga), .rst_vga(rst_vga), .en(1'b1),
        .cnt(div), .nxt(div_nxt), .wrap(div_wrap)
    );

    mod_counter #(.N(H_TOT), .W(INDEX_W)) u_h (
        .clk_vga(clk_vga), .rst_vga(rst_vga), .en(h_en),
        .cnt(h_index), .nxt(nxt.h), .wrap(h_wrap)
    );

    mod_counter #(.N(V_TOT), .W(INDEX_W)) u_v (
        .clk_vga(clk_vga), .rst_vga(rst_vga), .en(v_en),
        .cnt(v_index), .nxt(nxt.v), .wrap(v_wrap)
    );

    mod_counter #(.N(FRAMES_PER_SEC), .W(FW)) u_fc (
        .clk_vga(clk_vga), .rst_vga(rst_vga), .en(fc_en),
        .cnt(fc), .nxt(fc_nxt), .wrap(fc_wrap)
    );

    assign unused_bits = ^{div, fc, fc_nxt};

    always_comb begin
        h_n    = 32'(nxt.h);
        v_n    = 32'(nxt.v);
        hs_act = (h_n >= HS_S) && (h_n < HS_E);
        vs_act = (v_n >= VS_S) && (v_n < VS_E);
        vis    = (h_n < H_ACTIVE) && (v_n < V_ACTIVE);
    end

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            hsync      <= ~HSYNC_POL;
            vsync      <= ~VSYNC_POL;
            video_on   <= 1'b1;
            pix_tick   <= 1'b0;
            frame_tick <= 1'b0;
            sec_tick   <= 1'b0;
        end else begin
            hsync      <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync      <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            video_on   <= vis;
            pix_tick   <= (div_nxt == DW'(CLK_DIV - 1));
            frame_tick <= fc_en;
            sec_tick   <= fc_en & fc_wrap;
        end
    end

endmodule
